avalon_ram_agent: RTL
=====================

// Module: avalon_ram_agent
// PURPOSE
//  Avalon-MM agent (responder) fronting on-chip word RAM; the far end of the core's load/store host port.
//  Accepts one read or write at a time, applies byteenable on writes, returns full 32-bit words on reads.
//  Read latency and write stall are parameterised so benches and SoC builds exercise host wait paths.
// PARAMETERS
//  DEPTH_WORDS  1024  RAM depth in 32-bit words; power of two, >=4
//  READ_LATENCY 2     edges from read accept to edge sampling readdatavalid; >=1
//  WRITE_WAIT   0     extra waitrequest cycles before write accepted; 0..15
// PORTS
//  clk             in   1   clock, all logic on posedge
//  rst             in   1   reset, asynchronous, active-high
//  port            --   -   AvalonMmRw.Agent: address(32) byteenable(4) read write host_to_agent(32) in;
//                           agent_to_host(32) waitrequest readdatavalid out
// BEHAVIOUR
//  Reset: state=IDLE, waitrequest=1 while rst high, readdatavalid=0, agent_to_host=0, counters=0; RAM not cleared.
//  Index: widx = address[$clog2(DEPTH_WORDS)+1:2]; address[1:0] ignored; byteenable lanes applied as given.
//  Accept = edge where (read|write) && !waitrequest.
//  States: IDLE, WRITE_STALL, READ_PENDING, READ_RESPOND.
//  IDLE: waitrequest=0 unless write && WRITE_WAIT>0.
//   read -> accepted; latch widx; cnt=READ_LATENCY-1; cnt==0 ? READ_RESPOND : READ_PENDING.
//   write, WRITE_WAIT==0 -> accepted; lane i of RAM[widx] <= host_to_agent[8i+7:8i] where byteenable[i]; stay IDLE.
//   write, WRITE_WAIT>0 -> waitrequest=1 (combinational); -> WRITE_STALL, cnt=WRITE_WAIT-1.
//   read&&write together -> serviced as write, read dropped (SVA error outside synthesis).
//  WRITE_STALL: waitrequest=1 while cnt!=0, cnt--; at cnt==0 waitrequest=0, write accepted with current inputs -> IDLE.
//   Host drops write during stall -> no RAM update, -> IDLE.
//  READ_PENDING: waitrequest=1; cnt-- each edge; cnt==1 -> READ_RESPOND.
//  READ_RESPOND: readdatavalid=1 for exactly this cycle, agent_to_host=RAM[latched widx]; waitrequest=1; -> IDLE.
//   Data reflects any write accepted before the read; no other access can interleave.
//  agent_to_host holds last read data; changes only on entry to READ_RESPOND.
//  byteenable=0000 write: accepted, RAM unchanged. Read ignores byteenable (host truncates/extends).
//  Reset mid-operation: pending read abandoned, no readdatavalid; stalled write never committed.
// CONFIGURATION
//  AVALON_RAM_AGENT_ADDR_CHECK_EN defined: address >= DEPTH_WORDS*4 -> read returns 32'hDEAD_BEEF after
//   normal latency, write dropped after normal handshake; sticky output addr_error (reset 0) set.
//  Undefined: no addr_error port; widx wraps modulo DEPTH_WORDS, upper address bits ignored.
// STRUCTURE
//  Types package: word (existing), agent_state_t enum, BAD_ADDR_DATA = 32'hDEAD_BEEF.
//  Sub-module byte_en_ram: synchronous 4-lane byte-write, 1-cycle-read RAM, DEPTH_WORDS param; agent is FSM+counter.
// TESTING
//  1 Write 0x1122_3344 @0x10 be=1111, read 0x10, LAT=2 -> readdatavalid 2 edges after accept, data 0x1122_3344.
//  2 Then write 0xAAAA_AAAA @0x10 be=0001 -> read 0x1122_33AA; be=0000 -> unchanged.
//  3 WRITE_WAIT=3: waitrequest high 3 cycles, accept on 4th; read-back correct; drop write mid-stall -> no change.
//  4 LAT=1: readdatavalid one edge after accept; back-to-back reads 0x0,0x4 -> 2 responses, in order, 1 each.
//  5 rst during READ_PENDING -> readdatavalid stays 0; waitrequest 1 during rst, 0 in IDLE after release.
//  6 ADDR_CHECK_EN, DEPTH=1024: read 0x1000 -> 0xDEAD_BEEF, addr_error=1; without macro -> RAM[0].

Source files
------------

// File: rtl/avalon_ram_agent_pkg.sv
// avalon_ram_agent_pkg: shared word type, agent FSM states and the
// substitute data returned for out-of-range reads.
package avalon_ram_agent_pkg;

   typedef logic [31:0] word;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      WRITE_STALL  = 2'd1,
      READ_PENDING = 2'd2,
      READ_RESPOND = 2'd3
   } agent_state_t;

   localparam word BAD_ADDR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/avalon_ram_agent_byte_en_ram.sv
// byte_en_ram: single-port word RAM with four byte-write lanes and a
// registered one-cycle read. The read register only updates on re_i, so it
// holds the last word read between accesses. The array itself is never reset.
module byte_en_ram
   import avalon_ram_agent_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           we_i,
   input  logic [3:0]                     be_i,
   input  logic                           re_i,
   input  logic [$clog2(DEPTH_WORDS)-1:0] addr_i,
   input  logic [31:0]                    wdata_i,
   output logic [31:0]                    rdata_o
);

   word mem_q [DEPTH_WORDS];
   word rdata_q;

   // Byte-lane write: only lanes with their enable set are modified.
   always_ff @(posedge clk) begin
      if (we_i) begin
         for (int b = 0; b < 4; b++) begin
            if (be_i[b]) begin
               mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
         end
      end
   end

   // Read register: loads only when a read is requested, otherwise holds.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/avalon_ram_agent.sv
// avalon_ram_agent: Avalon-MM responder in front of an on-chip word RAM.
// One access at a time; reads return after READ_LATENCY edges with a single
// readdatavalid pulse, writes may be stalled WRITE_WAIT cycles.
// Optional feature macro AVALON_RAM_AGENT_ADDR_CHECK_EN: out-of-range
// accesses return 32'hDEAD_BEEF / drop the write and set sticky addr_error_o.
module avalon_ram_agent
   import avalon_ram_agent_pkg::*;
#(
   parameter int DEPTH_WORDS  = 1024,
   parameter int READ_LATENCY = 2,
   parameter int WRITE_WAIT   = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] address_i,
   input  logic [3:0]  byteenable_i,
   input  logic        read_i,
   input  logic        write_i,
   input  logic [31:0] host_to_agent_i,
   output logic [31:0] agent_to_host_o,
   output logic        waitrequest_o,
   output logic        readdatavalid_o
`ifdef AVALON_RAM_AGENT_ADDR_CHECK_EN
   ,
   output logic        addr_error_o
`endif
);

   localparam int AW    = $clog2(DEPTH_WORDS);
   localparam int RL_W  = $clog2(READ_LATENCY);
   localparam int CNT_W = (RL_W > 4) ? RL_W : 4;

   agent_state_t     state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [AW-1:0]    widx_q;
   logic             rdv_q;

   logic [AW-1:0]    widx;
   logic [AW-1:0]    ram_addr;
   logic             wait_int;
   logic             wr_accept;
   logic             rd_accept;
   logic             ram_we;
   logic             ram_re;
   logic             bad_in;
   logic [31:0]      ram_rdata;
   logic             unused_addr;

   assign widx        = address_i[AW+1:2];
   assign unused_addr = ^{address_i[31:AW+2], address_i[1:0]};

   // Waitrequest is combinational so a stalled write is held off in the same cycle.
   always_comb begin
      wait_int = 1'b1;
      unique case (state_q)
         IDLE:         wait_int = write_i && (WRITE_WAIT > 0);
         WRITE_STALL:  wait_int = (cnt_q != '0);
         READ_PENDING: wait_int = 1'b1;
         READ_RESPOND: wait_int = 1'b1;
      endcase
   end

   assign waitrequest_o   = rst | wait_int;
   assign wr_accept       = write_i && !waitrequest_o;
   assign rd_accept       = (state_q == IDLE) && read_i && !write_i && !waitrequest_o;
   assign ram_we          = wr_accept && !bad_in;
   assign ram_re          = (rd_accept && (READ_LATENCY == 1)) ||
                            ((state_q == READ_PENDING) && (cnt_q == CNT_W'(1)));
   assign ram_addr        = (state_q == READ_PENDING) ? widx_q : widx;
   assign readdatavalid_o = rdv_q;

   // Agent FSM: write stall countdown, read latency countdown, one-cycle response.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         widx_q  <= '0;
         rdv_q   <= 1'b0;
      end else begin
         rdv_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (write_i) begin
                  if (WRITE_WAIT > 0) begin
                     state_q <= WRITE_STALL;
                     cnt_q   <= CNT_W'(WRITE_WAIT - 1);
                  end
               end else if (read_i) begin
                  widx_q <= widx;
                  if (READ_LATENCY == 1) begin
                     state_q <= READ_RESPOND;
                     rdv_q   <= 1'b1;
                  end else begin
                     state_q <= READ_PENDING;
                     cnt_q   <= CNT_W'(READ_LATENCY - 1);
                  end
               end
            end
            WRITE_STALL: begin
               if (!write_i || (cnt_q == '0)) begin
                  state_q <= IDLE;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            READ_PENDING: begin
               cnt_q <= cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  state_q <= READ_RESPOND;
                  rdv_q   <= 1'b1;
               end
            end
            READ_RESPOND: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   byte_en_ram #(
      .DEPTH_WORDS (DEPTH_WORDS)
   ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .we_i    (ram_we),
      .be_i    (byteenable_i),
      .re_i    (ram_re),
      .addr_i  (ram_addr),
      .wdata_i (host_to_agent_i),
      .rdata_o (ram_rdata)
   );

`ifdef AVALON_RAM_AGENT_ADDR_CHECK_EN
   logic bad_q;
   logic resp_bad_q;
   logic addr_error_q;

   assign bad_in = |address_i[31:AW+2];

   // Range tracking: remember a bad read until its response, flag any bad accept.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bad_q        <= 1'b0;
         resp_bad_q   <= 1'b0;
         addr_error_q <= 1'b0;
      end else begin
         if (rd_accept) begin
            bad_q <= bad_in;
         end
         if (ram_re) begin
            resp_bad_q <= (state_q == READ_PENDING) ? bad_q : bad_in;
         end
         if ((wr_accept || rd_accept) && bad_in) begin
            addr_error_q <= 1'b1;
         end
      end
   end

   assign agent_to_host_o = resp_bad_q ? BAD_ADDR_DATA : ram_rdata;
   assign addr_error_o    = addr_error_q;
`else
   assign bad_in          = 1'b0;
   assign agent_to_host_o = ram_rdata;
`endif

`ifndef SYNTHESIS
   // A host must not request read and write together; the read is dropped.
   assert property (@(posedge clk) disable iff (rst) !(read_i && write_i))
      else $error("avalon_ram_agent: read and write asserted together, read dropped");
`endif

endmodule
